parity_frame_checker: RTL and testbench
=======================================

Name: parity_frame_checker

Overview:
Streaming, parametrised parity checker: one data word plus one parity bit per beat, with a per-beat valid qualifier and runtime odd/even mode. Checks every beat and aggregates results over fixed-length frames of FRAME_LEN beats. Reports a frame-level error flag and keeps a saturating error count. Sits behind the serial/parallel receive path, ahead of frame consumers.

Parameters:
DATA_W, 4, data bits per beat (>=1)
FRAME_LEN, 4, beats per frame (>=1)
CNT_W, 8, width of the saturating error counter

Ports:
clk  input  1  single clock, rising edge
rst  input  1  asynchronous, active-high reset
odd_mode  input  1  1 = odd parity expected, 0 = even; sampled per beat
in_valid  input  1  beat qualifier
in_data  input  DATA_W  data word
in_p  input  1  received parity bit
frame_sync  input  1  forces the current beat (or the next beat) to be beat 0
cnt_clr  input  1  synchronous clear of err_cnt
out_valid  output  1  registered copy of in_valid
word_err  output  1  parity error on the beat just reported
frame_done  output  1  one-cycle pulse on the last beat of a frame
frame_err  output  1  any beat of the completed frame errored; valid with frame_done
beat_idx  output  clog2(FRAME_LEN) (min 1)  index of the reported beat
err_cnt  output  CNT_W  saturating count of word errors

Behaviour:
- Reset (async, rst=1): all outputs 0, beat counter 0, frame-error accumulator 0, err_cnt 0.
- Parity check: ones = popcount(in_data) + in_p.
  - odd_mode=1: error when ones is even.
  - odd_mode=0: error when ones is odd.
- Latency: exactly 1 cycle. A beat accepted at edge N appears on out_valid/word_err/beat_idx after edge N. No backpressure; every valid beat is accepted.
- in_valid=0: out_valid=0, word_err=0, frame_done=0. Beat counter and accumulator hold. beat_idx holds its last value.
- Beat counter counts 0..FRAME_LEN-1 on valid beats and wraps to 0 after FRAME_LEN-1.
- Accumulator:
  - On beat 0 it loads err.
  - On later beats it ORs in err.
  - On the last beat, frame_err = accumulated OR this beat's err, and frame_done=1. The accumulator then clears.
- FRAME_LEN=1: every valid beat produces frame_done, and frame_err equals word_err.
- frame_sync with in_valid=1: the beat is treated as beat 0 and the partial frame is discarded with no frame_done.
- frame_sync with in_valid=0: counter and accumulator reset to 0, so the next valid beat is beat 0.
- err_cnt:
  - Increments on each valid beat with err.
  - Saturates at 2^CNT_W-1 and never wraps.
  - cnt_clr has priority, but an error in the same cycle is still counted, so err_cnt becomes 1 (otherwise 0).
- odd_mode may change between beats; each beat uses the value sampled with it.
- Reset mid-frame: partial frame discarded, no frame_done, all state returns to reset values.

Optional Feature:
Macro PARITY_FRAME_STICKY_EN.
- Defined: adds output sticky_err (1 bit). It sets on any frame_done with frame_err=1 and holds until cnt_clr or rst. Reset value 0.
- Undefined: port absent, no extra logic; all other behaviour identical.

Decomposition:
- Shared package parity_pkg:
  - PAR_ODD=1'b1 and PAR_EVEN=1'b0 constants.
  - Function returning clog2 for the beat_idx width.
- Sub-module parity_calc (combinational): in_data, in_p, odd_mode -> err. It is a width-generic reduction XOR and is reused by future parity generators.
- Top parity_frame_checker holds the beat counter, accumulator, counter and output registers.

Test Plan:
- Reset: assert rst asynchronously mid-cycle -> all outputs 0 immediately. Release, then feed DATA_W=4 beats -> beat_idx starts at 0.
- Odd mode sweep: in_data 0000..1111 with correct odd parity (p = ~^data) -> word_err=0 for all 16. Flip p -> word_err=1 on all 16, err_cnt=16.
- Even mode: odd_mode=0, data=4'b0011, p=0 -> word_err=0. Data=4'b0111, p=0 -> word_err=1.
- Frame aggregation: FRAME_LEN=4, beat 2 errored, in_valid gaps between beats -> frame_done only after beat 3 with frame_err=1. Next clean frame -> frame_err=0.
- frame_sync: assert frame_sync on beat 2 of a frame -> beat_idx=0 for that beat, no frame_done for the aborted frame, and the next frame_done comes 3 beats later.
- Saturation and clear: CNT_W=3, 9 errored beats -> err_cnt=7. Then cnt_clr with an errored beat -> err_cnt=1. Then cnt_clr with a clean beat -> err_cnt=0.

Source files
------------

// File: rtl/parity_pkg.sv
// Shared parity constants and helpers for the parity checker/generator family.
package parity_pkg;

  localparam logic PAR_ODD  = 1'b1;
  localparam logic PAR_EVEN = 1'b0;

  // Width of a 0..n-1 index; never narrower than one bit.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/parity_calc.sv
// Width-generic combinational parity check: flags a word whose total ones count
// (data plus parity bit) disagrees with the selected odd/even mode.
module parity_calc
  import parity_pkg::*;
#(
  parameter int unsigned DATA_W = 4
) (
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_p,
  input  logic              odd_mode,
  output logic              err
);

  // Reduction XOR is 1 for an odd ones count, so odd mode errors when it is 0.
  assign err = (^{in_data, in_p}) ^ (odd_mode == PAR_ODD);

endmodule

// File: rtl/parity_frame_checker.sv
// Streaming per-beat parity checker with fixed-length frame aggregation and a
// saturating error counter. Define PARITY_FRAME_STICKY_EN to add sticky_err.
module parity_frame_checker
  import parity_pkg::*;
#(
  parameter int unsigned DATA_W    = 4,
  parameter int unsigned FRAME_LEN = 4,
  parameter int unsigned CNT_W     = 8,
  localparam int unsigned IdxW     = idx_width(FRAME_LEN)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              odd_mode,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_p,
  input  logic              frame_sync,
  input  logic              cnt_clr,
  output logic              out_valid,
  output logic              word_err,
  output logic              frame_done,
  output logic              frame_err,
  output logic [IdxW-1:0]   beat_idx,
`ifdef PARITY_FRAME_STICKY_EN
  output logic              sticky_err,
`endif
  output logic [CNT_W-1:0]  err_cnt
);

  localparam logic [IdxW-1:0]  LastIdx = IdxW'(FRAME_LEN - 1);
  localparam logic [CNT_W-1:0] CntMax  = '1;

  logic            err;
  logic            hit;
  logic [IdxW-1:0] cnt_q, cnt_d, cur_idx, beat_idx_d;
  logic            acc_q, acc_d, acc_in;
  logic            done_d, ferr_d;
  logic [CNT_W-1:0] err_cnt_d;

  parity_calc #(
    .DATA_W(DATA_W)
  ) u_calc (
    .in_data (in_data),
    .in_p    (in_p),
    .odd_mode(odd_mode),
    .err     (err)
  );

  assign hit = in_valid & err;

  always_comb begin
    // A sync on a valid beat restarts the frame at this very beat.
    cur_idx    = frame_sync ? '0 : cnt_q;
    acc_in     = (cur_idx == '0) ? err : (acc_q | err);
    cnt_d      = cnt_q;
    acc_d      = acc_q;
    done_d     = 1'b0;
    ferr_d     = 1'b0;
    beat_idx_d = beat_idx;
    if (in_valid) begin
      beat_idx_d = cur_idx;
      if (cur_idx == LastIdx) begin
        done_d = 1'b1;
        ferr_d = acc_in;
        cnt_d  = '0;
        acc_d  = 1'b0;
      end else begin
        cnt_d = cur_idx + 1'b1;
        acc_d = acc_in;
      end
    end else if (frame_sync) begin
      cnt_d = '0;
      acc_d = 1'b0;
    end
  end

  // Clear wins, but an error arriving with the clear is still counted.
  always_comb begin
    err_cnt_d = err_cnt;
    if (cnt_clr) begin
      err_cnt_d = hit ? CNT_W'(1) : '0;
    end else if (hit && (err_cnt != CntMax)) begin
      err_cnt_d = err_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q      <= '0;
      acc_q      <= 1'b0;
      out_valid  <= 1'b0;
      word_err   <= 1'b0;
      frame_done <= 1'b0;
      frame_err  <= 1'b0;
      beat_idx   <= '0;
      err_cnt    <= '0;
    end else begin
      cnt_q      <= cnt_d;
      acc_q      <= acc_d;
      out_valid  <= in_valid;
      word_err   <= hit;
      frame_done <= done_d;
      frame_err  <= ferr_d;
      beat_idx   <= beat_idx_d;
      err_cnt    <= err_cnt_d;
    end
  end

`ifdef PARITY_FRAME_STICKY_EN
  logic sticky_set;
  assign sticky_set = done_d & ferr_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sticky_err <= 1'b0;
    end else if (cnt_clr) begin
      sticky_err <= sticky_set;
    end else begin
      sticky_err <= sticky_err | sticky_set;
    end
  end
`endif

endmodule

// File: tb/tb_parity_frame_checker.sv
// Directed self-checking bench for parity_frame_checker; a second instance with
// a 3-bit counter shares the stimulus to exercise saturation.
module tb_parity_frame_checker;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       odd_mode = 1'b1;
  logic       in_valid = 1'b0;
  logic [3:0] in_data = '0;
  logic       in_p = 1'b0;
  logic       frame_sync = 1'b0;
  logic       cnt_clr = 1'b0;

  logic       out_valid, word_err, frame_done, frame_err;
  logic [1:0] beat_idx;
  logic [7:0] err_cnt;
  logic       s_valid, s_werr, s_done, s_ferr;
  logic [1:0] s_idx;
  logic [2:0] s_cnt;
`ifdef PARITY_FRAME_STICKY_EN
  logic       sticky_err, s_sticky;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  parity_frame_checker #(
    .DATA_W(4), .FRAME_LEN(4), .CNT_W(8)
  ) u_dut (
    .clk(clk), .rst(rst), .odd_mode(odd_mode), .in_valid(in_valid),
    .in_data(in_data), .in_p(in_p), .frame_sync(frame_sync), .cnt_clr(cnt_clr),
    .out_valid(out_valid), .word_err(word_err), .frame_done(frame_done),
    .frame_err(frame_err), .beat_idx(beat_idx),
`ifdef PARITY_FRAME_STICKY_EN
    .sticky_err(sticky_err),
`endif
    .err_cnt(err_cnt)
  );

  parity_frame_checker #(
    .DATA_W(4), .FRAME_LEN(4), .CNT_W(3)
  ) u_sat (
    .clk(clk), .rst(rst), .odd_mode(odd_mode), .in_valid(in_valid),
    .in_data(in_data), .in_p(in_p), .frame_sync(frame_sync), .cnt_clr(cnt_clr),
    .out_valid(s_valid), .word_err(s_werr), .frame_done(s_done),
    .frame_err(s_ferr), .beat_idx(s_idx),
`ifdef PARITY_FRAME_STICKY_EN
    .sticky_err(s_sticky),
`endif
    .err_cnt(s_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of inputs, then sit 1 time unit past the edge for sampling.
  task automatic beat(input logic v, input logic [3:0] d, input logic p, input logic m,
                      input logic s, input logic c);
    in_valid = v; in_data = d; in_p = p; odd_mode = m; frame_sync = s; cnt_clr = c;
    @(posedge clk);
    #1;
    in_valid = 1'b0; frame_sync = 1'b0; cnt_clr = 1'b0;
  endtask

  initial begin
    logic [3:0] d;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", out_valid, 0);
    chk("rst_done", frame_done, 0);
    chk("rst_idx", beat_idx, 0);
    chk("rst_cnt", err_cnt, 0);
    rst = 1'b0;

    // Build some state, then reset asynchronously mid-cycle
    beat(1, 4'b0001, 1, 1, 0, 0);
    chk("pre_werr", word_err, 1);
    chk("pre_cnt", err_cnt, 1);
    beat(1, 4'b0000, 1, 1, 0, 0);
    chk("pre_idx", beat_idx, 1);
    #3 rst = 1'b1;
    #1;
    chk("arst_valid", out_valid, 0);
    chk("arst_idx", beat_idx, 0);
    chk("arst_cnt", err_cnt, 0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    beat(1, 4'b0000, 1, 1, 0, 0);
    chk("post_rst_idx", beat_idx, 0);
    chk("post_rst_werr", word_err, 0);
    beat(0, 4'b0000, 0, 1, 1, 0);
    chk("idle_valid", out_valid, 0);

    // Odd mode sweep, correct parity then flipped parity
    for (int i = 0; i < 16; i++) begin
      d = 4'(i);
      beat(1, d, ~^d, 1, 0, 0);
      chk("odd_ok_werr", word_err, 0);
      chk("odd_ok_idx", beat_idx, 32'(i % 4));
      chk("odd_ok_done", frame_done, (i % 4 == 3) ? 1 : 0);
      chk("odd_ok_ferr", frame_err, 0);
    end
    for (int i = 0; i < 16; i++) begin
      d = 4'(i);
      beat(1, d, ^d, 1, 0, 0);
      chk("odd_bad_werr", word_err, 1);
      chk("odd_bad_ferr", frame_err, (i % 4 == 3) ? 1 : 0);
    end
    chk("sweep_cnt", err_cnt, 16);
    chk("sweep_sat_cnt", s_cnt, 7);
`ifdef PARITY_FRAME_STICKY_EN
    chk("sticky_set", sticky_err, 1);
`endif

    // Even mode
    beat(1, 4'b0011, 0, 0, 0, 0);
    chk("even_ok", word_err, 0);
    beat(1, 4'b0111, 0, 0, 0, 0);
    chk("even_bad", word_err, 1);
    chk("even_cnt", err_cnt, 17);
    beat(0, 4'b0000, 0, 1, 1, 0);
    chk("sync_idle_done", frame_done, 0);

    // Frame aggregation with valid gaps; error on beat 2
    beat(1, 4'b0000, 1, 1, 0, 0);
    chk("agg_b0_idx", beat_idx, 0);
    beat(0, 4'b0000, 0, 1, 0, 0);
    chk("agg_gap_valid", out_valid, 0);
    beat(1, 4'b0000, 1, 1, 0, 0);
    chk("agg_b1_done", frame_done, 0);
    beat(0, 4'b0000, 0, 1, 0, 0);
    beat(1, 4'b0000, 0, 1, 0, 0);
    chk("agg_b2_werr", word_err, 1);
    chk("agg_b2_done", frame_done, 0);
    beat(0, 4'b0000, 0, 1, 0, 0);
    beat(0, 4'b0000, 0, 1, 0, 0);
    chk("agg_gap_hold_idx", beat_idx, 2);
    chk("agg_gap_werr", word_err, 0);
    beat(1, 4'b0001, 0, 1, 0, 0);
    chk("agg_b3_idx", beat_idx, 3);
    chk("agg_b3_done", frame_done, 1);
    chk("agg_b3_ferr", frame_err, 1);
    for (int i = 0; i < 4; i++) beat(1, 4'b0000, 1, 1, 0, 0);
    chk("clean_done", frame_done, 1);
    chk("clean_ferr", frame_err, 0);

    // frame_sync on beat 2 discards the partial frame (which holds an error)
    beat(1, 4'b0000, 1, 1, 0, 0);
    beat(1, 4'b0000, 0, 1, 0, 0);
    chk("fs_b1_idx", beat_idx, 1);
    beat(1, 4'b0000, 1, 1, 1, 0);
    chk("fs_idx", beat_idx, 0);
    chk("fs_done", frame_done, 0);
    for (int i = 1; i < 4; i++) begin
      beat(1, 4'b0000, 1, 1, 0, 0);
      chk("fs_after_idx", beat_idx, 32'(i));
      chk("fs_after_done", frame_done, (i == 3) ? 1 : 0);
    end
    chk("fs_ferr", frame_err, 0);
    chk("fs_cnt", err_cnt, 19);

    // Saturation and clear
    beat(0, 4'b0000, 0, 1, 0, 1);
    chk("clr_cnt", err_cnt, 0);
    chk("clr_sat_cnt", s_cnt, 0);
`ifdef PARITY_FRAME_STICKY_EN
    chk("sticky_clr", sticky_err, 0);
`endif
    for (int i = 0; i < 9; i++) beat(1, 4'b0000, 0, 1, 0, 0);
    chk("sat_cnt", s_cnt, 7);
    chk("nosat_cnt", err_cnt, 9);
    beat(1, 4'b0000, 0, 1, 0, 1);
    chk("clr_err_sat", s_cnt, 1);
    chk("clr_err_cnt", err_cnt, 1);
    beat(1, 4'b0000, 1, 1, 0, 1);
    chk("clr_ok_sat", s_cnt, 0);
    chk("clr_ok_cnt", err_cnt, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
